// File: rtl/conv2d_pkg.sv
// Shared types and sizing helpers for the streaming Q-format 2-D convolution engine.
package conv2d_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MAC,
        S_REQ,
        S_OUT,
        S_DONE
    } state_t;

    // Output pixel position; doubles as the filter/row/col being computed.
    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] row;
        logic [7:0] col;
    } pix_idx_t;

    function automatic int out_dim(int in_sz, int k, int s, int p, int d);
        return (in_sz + 2*p - d*(k-1) - 1) / s + 1;
    endfunction

    function automatic int acc_w(int dw, int ic, int k);
        return 2*dw + $clog2(ic*k*k + 1) + 1;
    endfunction

    function automatic int in_idx(int c, int r, int x, int h, int w);
        return (c*h + r)*w + x;
    endfunction

    function automatic int w_idx(int o, int c, int kr, int kc, int ic, int k);
        return ((o*ic + c)*k + kr)*k + kc;
    endfunction

endpackage

// File: rtl/conv2d_requant.sv
// Round-to-nearest (half up), arithmetic shift and saturation of an accumulator.
// CONV_RELU_EN: negative saturated results are forced to zero.
module conv2d_requant
    import conv2d_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_W      = 38
) (
    input  logic signed [ACC_W-1:0]      acc,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         sat
);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    logic signed [ACC_W-1:0] rnd;

    generate
        if (FRAC_BITS > 0) begin : g_rnd
            localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
            assign rnd = (acc + HALF) >>> FRAC_BITS;
        end else begin : g_nornd
            assign rnd = acc;
        end
    endgenerate

    always_comb begin
        sat    = 1'b0;
        result = rnd[DATA_WIDTH-1:0];
        if (rnd > MAXV) begin
            result = MAXV[DATA_WIDTH-1:0];
            sat    = 1'b1;
        end else if (rnd < MINV) begin
            result = MINV[DATA_WIDTH-1:0];
            sat    = 1'b1;
        end
`ifdef CONV_RELU_EN
        // sat already reflects the pre-ReLU clamp
        if (result[DATA_WIDTH-1])
            result = '0;
`endif
    end

endmodule

// File: rtl/conv2d_stream_q.sv
// Sequential dilated 2-D convolution, one MAC per cycle, one result beat per output pixel.
// CONV_RELU_EN (optional): apply ReLU after saturation in the requantiser.
module conv2d_stream_q
    import conv2d_pkg::*;
#(
    parameter int IN_CHANNELS  = 2,
    parameter int OUT_CHANNELS = 2,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int PADDING      = 1,
    parameter int DILATION     = 1,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 8
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   start,
    input  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]   input_tensor_flat,
    input  logic [OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_flat,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                     bias_flat,
    output logic                                                   busy,
    output logic                                                   done,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [DATA_WIDTH-1:0]                                  out_data,
    output logic [7:0]                                             out_ch,
    output logic [7:0]                                             out_row,
    output logic [7:0]                                             out_col,
    output logic                                                   sat_flag
);
    localparam int K     = KERNEL_SIZE;
    localparam int OUT_H = out_dim(IN_HEIGHT, K, STRIDE, PADDING, DILATION);
    localparam int OUT_W = out_dim(IN_WIDTH, K, STRIDE, PADDING, DILATION);
    localparam int ACC_W = acc_w(DATA_WIDTH, IN_CHANNELS, K);

    state_t   state, state_nxt;
    pix_idx_t pix;
    logic [7:0] c_cnt, kr_cnt, kc_cnt;
    logic signed [ACC_W-1:0]        acc;
    logic signed [DATA_WIDTH-1:0]   smp, wgt, bias_s, rq_data;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic rq_sat, last_tap, last_beat, in_rng;
    int   ir, ic;

    assign out_ch  = pix.ch;
    assign out_row = pix.row;
    assign out_col = pix.col;

    assign last_tap  = (c_cnt == 8'(IN_CHANNELS-1)) && (kr_cnt == 8'(K-1)) && (kc_cnt == 8'(K-1));
    assign last_beat = (pix.ch == 8'(OUT_CHANNELS-1)) && (pix.row == 8'(OUT_H-1)) && (pix.col == 8'(OUT_W-1));
    assign bias_s    = bias_flat[int'(pix.ch)*DATA_WIDTH +: DATA_WIDTH];

    // Tap fetch: padded positions read as zero rather than indexing the tensor.
    always_comb begin
        ir     = int'(pix.row)*STRIDE + int'(kr_cnt)*DILATION - PADDING;
        ic     = int'(pix.col)*STRIDE + int'(kc_cnt)*DILATION - PADDING;
        in_rng = (ir >= 0) && (ir < IN_HEIGHT) && (ic >= 0) && (ic < IN_WIDTH);
        smp    = '0;
        if (in_rng)
            smp = input_tensor_flat[in_idx(int'(c_cnt), ir, ic, IN_HEIGHT, IN_WIDTH)*DATA_WIDTH +: DATA_WIDTH];
        wgt  = weights_flat[w_idx(int'(pix.ch), int'(c_cnt), int'(kr_cnt), int'(kc_cnt), IN_CHANNELS, K)*DATA_WIDTH +: DATA_WIDTH];
        prod = smp * wgt;
    end

    conv2d_requant #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_requant (
        .acc   (acc),
        .result(rq_data),
        .sat   (rq_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_INIT;
            S_INIT: begin busy = 1'b1; state_nxt = S_MAC; end
            S_MAC:  begin busy = 1'b1; if (last_tap) state_nxt = S_REQ; end
            S_REQ:  begin busy = 1'b1; state_nxt = S_OUT; end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = last_beat ? S_DONE : S_INIT;
            end
            S_DONE: begin done = 1'b1; state_nxt = S_IDLE; end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            c_cnt    <= '0;
            kr_cnt   <= '0;
            kc_cnt   <= '0;
            pix      <= '0;
            out_data <= '0;
            sat_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    sat_flag <= 1'b0;
                    pix      <= '0;
                end
                S_INIT: begin
                    acc    <= ACC_W'(bias_s) <<< FRAC_BITS;
                    c_cnt  <= '0;
                    kr_cnt <= '0;
                    kc_cnt <= '0;
                end
                S_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (kc_cnt == 8'(K-1)) begin
                        kc_cnt <= '0;
                        if (kr_cnt == 8'(K-1)) begin
                            kr_cnt <= '0;
                            c_cnt  <= last_tap ? '0 : c_cnt + 8'd1;
                        end else begin
                            kr_cnt <= kr_cnt + 8'd1;
                        end
                    end else begin
                        kc_cnt <= kc_cnt + 8'd1;
                    end
                end
                S_REQ: begin
                    out_data <= rq_data;
                    if (rq_sat) sat_flag <= 1'b1;
                end
                S_OUT: if (out_ready && !last_beat) begin
                    if (pix.col == 8'(OUT_W-1)) begin
                        pix.col <= '0;
                        if (pix.row == 8'(OUT_H-1)) begin
                            pix.row <= '0;
                            pix.ch  <= pix.ch + 8'd1;
                        end else begin
                            pix.row <= pix.row + 8'd1;
                        end
                    end else begin
                        pix.col <= pix.col + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
